// File: rtl/ct_mat_pkg.sv
// Shared matrix-unit constants, tile-size widths and load-sequencer state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ct_mat_pkg;

    localparam int SIZE_K_WIDTH   = 16;
    localparam int SIZE_M_WIDTH   = 8;
    localparam int SIZE_N_WIDTH   = 8;
    localparam int MAT_ADDR_WIDTH = 40;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_ISSUE = 2'd1,
        LD_DONE  = 2'd2
    } ldSeqState_e;

    // Row count of a load: the B operand walks N rows, A/C operands walk M rows.
    function automatic logic [SIZE_M_WIDTH-1:0] selRowCnt(
        input logic                    useN,
        input logic [SIZE_M_WIDTH-1:0] sizeM,
        input logic [SIZE_N_WIDTH-1:0] sizeN
    );
        return useN ? sizeN : sizeM;
    endfunction

endpackage

// File: rtl/ct_mat_lsu_ld_row_seq.sv
// Matrix load row sequencer: snapshots tile sizes/base/stride on issue, emits one LSU row request per row.
// Latency: first request one cycle after sel; done pulse one cycle after the last row handshake.
// Backpressure: request payload held while req_vld & !req_rdy; flush aborts at any point.
//
// Ports:
//   forever_cpuclk, cpurst_b                  clock, async active-low reset
//   idu_mat_rf_ld_*                           issue strobe plus base, stride, operand select, iid
//   x_sizeK / x_sizeM / x_sizeN               configured tile sizes (sampled only on issue)
//   rtu_yy_xx_flush                           pipeline flush, overrides everything
//   mat_lsu_req_* / lsu_mat_req_rdy           row request channel to the LSU (valid/ready)
//   mat_idu_ld_busy, mat_idu_ld_done_*        occupancy and completion report to the IDU
module ct_mat_lsu_ld_row_seq
    import ct_mat_pkg::*;
#(
    parameter int ADDR_WIDTH = MAT_ADDR_WIDTH,
    parameter int IID_WIDTH  = 7
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    idu_mat_rf_ld_sel,
    input  logic [ADDR_WIDTH-1:0]   idu_mat_rf_ld_base,
    input  logic [ADDR_WIDTH-1:0]   idu_mat_rf_ld_stride,
    input  logic                    idu_mat_rf_ld_use_n,
    input  logic [IID_WIDTH-1:0]    idu_mat_rf_ld_iid,
    input  logic [SIZE_K_WIDTH-1:0] x_sizeK,
    input  logic [SIZE_M_WIDTH-1:0] x_sizeM,
    input  logic [SIZE_N_WIDTH-1:0] x_sizeN,
    input  logic                    rtu_yy_xx_flush,
    input  logic                    lsu_mat_req_rdy,
    output logic                    mat_lsu_req_vld,
    output logic [ADDR_WIDTH-1:0]   mat_lsu_req_addr,
    output logic [SIZE_K_WIDTH-1:0] mat_lsu_req_bytes,
    output logic [SIZE_M_WIDTH-1:0] mat_lsu_req_row,
    output logic                    mat_lsu_req_last,
    output logic [IID_WIDTH-1:0]    mat_lsu_req_iid,
    output logic                    mat_idu_ld_busy,
    output logic                    mat_idu_ld_done_vld,
    output logic [IID_WIDTH-1:0]    mat_idu_ld_done_iid,
    output logic                    mat_idu_ld_done_empty
);

    ldSeqState_e             curState;
    ldSeqState_e             nextState;

    logic [ADDR_WIDTH-1:0]   curAddr;
    logic [ADDR_WIDTH-1:0]   snapStride;
    logic [IID_WIDTH-1:0]    snapIid;
    logic [SIZE_K_WIDTH-1:0] snapBytes;
    logic [SIZE_M_WIDTH-1:0] snapRows;
    logic [SIZE_M_WIDTH-1:0] rowIdx;
    logic                    snapEmpty;

    logic [SIZE_M_WIDTH-1:0] issueRows;
    logic                    issuing;
    logic                    lastRow;
    logic                    reqHs;
    logic                    startLoad;
    logic                    zeroLoad;
    logic                    advance;

    assign issueRows = selRowCnt(idu_mat_rf_ld_use_n, x_sizeM, x_sizeN);
    assign issuing   = (curState == LD_ISSUE);
    // snapRows is never 0 while issuing, so the subtraction cannot underflow.
    assign lastRow   = (rowIdx == (snapRows - 8'd1));
    assign reqHs     = issuing & lsu_mat_req_rdy;

    //------------------------------------------------------------------
    // Next-state and datapath-enable decode
    //------------------------------------------------------------------
    always_comb begin
        nextState = curState;
        startLoad = 1'b0;
        zeroLoad  = 1'b0;
        advance   = 1'b0;
        case (curState)
            LD_IDLE: begin
                // sel while busy is an IDU protocol error and is simply not decoded.
                if (idu_mat_rf_ld_sel) begin
                    if ((issueRows == '0) || (x_sizeK == '0)) begin
                        nextState = LD_DONE;
                        zeroLoad  = 1'b1;
                    end else begin
                        nextState = LD_ISSUE;
                        startLoad = 1'b1;
                    end
                end
            end
            LD_ISSUE: begin
                if (reqHs) begin
                    if (lastRow) begin
                        nextState = LD_DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            LD_DONE: begin
                nextState = LD_IDLE;
            end
            default: begin
                nextState = LD_IDLE;
            end
        endcase
        // Flush beats a same-cycle sel and a same-cycle final handshake.
        if (rtu_yy_xx_flush) begin
            nextState = LD_IDLE;
            startLoad = 1'b0;
            zeroLoad  = 1'b0;
            advance   = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            curState <= LD_IDLE;
        end else begin
            curState <= nextState;
        end
    end

    //------------------------------------------------------------------
    // Snapshot registers, row counter and address accumulator
    //------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            curAddr    <= '0;
            snapStride <= '0;
            snapIid    <= '0;
            snapBytes  <= '0;
            snapRows   <= '0;
            rowIdx     <= '0;
            snapEmpty  <= 1'b0;
        end else if (startLoad) begin
            curAddr    <= idu_mat_rf_ld_base;
            snapStride <= idu_mat_rf_ld_stride;
            snapIid    <= idu_mat_rf_ld_iid;
            snapBytes  <= x_sizeK;
            snapRows   <= issueRows;
            rowIdx     <= '0;
            snapEmpty  <= 1'b0;
        end else if (zeroLoad) begin
            snapIid    <= idu_mat_rf_ld_iid;
            snapEmpty  <= 1'b1;
        end else if (advance) begin
            // Wraps modulo 2^ADDR_WIDTH by construction of the register width.
            curAddr    <= curAddr + snapStride;
            rowIdx     <= rowIdx + 8'd1;
        end
    end

    //------------------------------------------------------------------
    // Outputs: decoded from state so an async reset clears them at once,
    // and payload reads zero outside the states that own it.
    //------------------------------------------------------------------
    assign mat_lsu_req_vld       = issuing;
    assign mat_lsu_req_addr      = issuing ? curAddr   : '0;
    assign mat_lsu_req_bytes     = issuing ? snapBytes : '0;
    assign mat_lsu_req_row       = issuing ? rowIdx    : '0;
    assign mat_lsu_req_last      = issuing & lastRow;
    assign mat_lsu_req_iid       = issuing ? snapIid   : '0;
    assign mat_idu_ld_busy       = (curState != LD_IDLE);
    assign mat_idu_ld_done_vld   = (curState == LD_DONE);
    assign mat_idu_ld_done_iid   = (curState == LD_DONE) ? snapIid : '0;
    assign mat_idu_ld_done_empty = (curState == LD_DONE) & snapEmpty;

endmodule

// File: tb/tb_ct_mat_lsu_ld_row_seq.sv
// Directed bench for the matrix load row sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Summary line reports compared / mismatched counts.
module tb_ct_mat_lsu_ld_row_seq;

    logic        forever_cpuclk;
    logic        cpurst_b;
    logic        idu_mat_rf_ld_sel;
    logic [39:0] idu_mat_rf_ld_base;
    logic [39:0] idu_mat_rf_ld_stride;
    logic        idu_mat_rf_ld_use_n;
    logic [6:0]  idu_mat_rf_ld_iid;
    logic [15:0] x_sizeK;
    logic [7:0]  x_sizeM;
    logic [7:0]  x_sizeN;
    logic        rtu_yy_xx_flush;
    logic        lsu_mat_req_rdy;
    logic        mat_lsu_req_vld;
    logic [39:0] mat_lsu_req_addr;
    logic [15:0] mat_lsu_req_bytes;
    logic [7:0]  mat_lsu_req_row;
    logic        mat_lsu_req_last;
    logic [6:0]  mat_lsu_req_iid;
    logic        mat_idu_ld_busy;
    logic        mat_idu_ld_done_vld;
    logic [6:0]  mat_idu_ld_done_iid;
    logic        mat_idu_ld_done_empty;

    int compCnt;
    int missCnt;

    ct_mat_lsu_ld_row_seq #(.ADDR_WIDTH(40), .IID_WIDTH(7)) u_dut (
        .forever_cpuclk        (forever_cpuclk),
        .cpurst_b              (cpurst_b),
        .idu_mat_rf_ld_sel     (idu_mat_rf_ld_sel),
        .idu_mat_rf_ld_base    (idu_mat_rf_ld_base),
        .idu_mat_rf_ld_stride  (idu_mat_rf_ld_stride),
        .idu_mat_rf_ld_use_n   (idu_mat_rf_ld_use_n),
        .idu_mat_rf_ld_iid     (idu_mat_rf_ld_iid),
        .x_sizeK               (x_sizeK),
        .x_sizeM               (x_sizeM),
        .x_sizeN               (x_sizeN),
        .rtu_yy_xx_flush       (rtu_yy_xx_flush),
        .lsu_mat_req_rdy       (lsu_mat_req_rdy),
        .mat_lsu_req_vld       (mat_lsu_req_vld),
        .mat_lsu_req_addr      (mat_lsu_req_addr),
        .mat_lsu_req_bytes     (mat_lsu_req_bytes),
        .mat_lsu_req_row       (mat_lsu_req_row),
        .mat_lsu_req_last      (mat_lsu_req_last),
        .mat_lsu_req_iid       (mat_lsu_req_iid),
        .mat_idu_ld_busy       (mat_idu_ld_busy),
        .mat_idu_ld_done_vld   (mat_idu_ld_done_vld),
        .mat_idu_ld_done_iid   (mat_idu_ld_done_iid),
        .mat_idu_ld_done_empty (mat_idu_ld_done_empty)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    // The IDU must never issue while the sequencer is occupied.
    always @(posedge forever_cpuclk) begin
        if (cpurst_b) begin
            assert (!(idu_mat_rf_ld_sel && mat_idu_ld_busy))
                else $error("illegal sel while busy");
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compCnt++;
        if (obs !== exp) begin
            missCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge forever_cpuclk);
        #1;
    endtask

    // Presents sel for one cycle; returns in the T+1 view.
    task automatic startOp(input logic [39:0] base, input logic [39:0] stride, input logic useN,
                           input logic [7:0] m, input logic [7:0] n, input logic [15:0] k,
                           input logic [6:0] iid);
        idu_mat_rf_ld_base   = base;
        idu_mat_rf_ld_stride = stride;
        idu_mat_rf_ld_use_n  = useN;
        x_sizeM              = m;
        x_sizeN              = n;
        x_sizeK              = k;
        idu_mat_rf_ld_iid    = iid;
        idu_mat_rf_ld_sel    = 1'b1;
        step();
        idu_mat_rf_ld_sel    = 1'b0;
    endtask

    task automatic expectReq(input string tag, input logic [39:0] addr, input logic [15:0] bytes,
                             input logic [7:0] row, input logic last, input logic [6:0] iid);
        checkVal({tag, ".vld"},   64'(mat_lsu_req_vld),   64'd1);
        checkVal({tag, ".addr"},  64'(mat_lsu_req_addr),  64'(addr));
        checkVal({tag, ".bytes"}, 64'(mat_lsu_req_bytes), 64'(bytes));
        checkVal({tag, ".row"},   64'(mat_lsu_req_row),   64'(row));
        checkVal({tag, ".last"},  64'(mat_lsu_req_last),  64'(last));
        checkVal({tag, ".iid"},   64'(mat_lsu_req_iid),   64'(iid));
    endtask

    task automatic expectDone(input string tag, input logic [6:0] iid, input logic empty);
        checkVal({tag, ".done_vld"},   64'(mat_idu_ld_done_vld),   64'd1);
        checkVal({tag, ".done_iid"},   64'(mat_idu_ld_done_iid),   64'(iid));
        checkVal({tag, ".done_empty"}, 64'(mat_idu_ld_done_empty), 64'(empty));
        checkVal({tag, ".req_vld"},    64'(mat_lsu_req_vld),       64'd0);
        checkVal({tag, ".busy"},       64'(mat_idu_ld_busy),       64'd1);
    endtask

    task automatic expectIdle(input string tag);
        checkVal({tag, ".busy"},     64'(mat_idu_ld_busy),     64'd0);
        checkVal({tag, ".done_vld"}, 64'(mat_idu_ld_done_vld), 64'd0);
        checkVal({tag, ".req_vld"},  64'(mat_lsu_req_vld),     64'd0);
    endtask

    initial begin
        compCnt              = 0;
        missCnt              = 0;
        cpurst_b             = 1'b0;
        idu_mat_rf_ld_sel    = 1'b0;
        idu_mat_rf_ld_base   = '0;
        idu_mat_rf_ld_stride = '0;
        idu_mat_rf_ld_use_n  = 1'b0;
        idu_mat_rf_ld_iid    = '0;
        x_sizeK              = '0;
        x_sizeM              = '0;
        x_sizeN              = '0;
        rtu_yy_xx_flush      = 1'b0;
        lsu_mat_req_rdy      = 1'b1;

        // Reset state
        step();
        step();
        expectIdle("rst");
        checkVal("rst.addr",  64'(mat_lsu_req_addr),      64'd0);
        checkVal("rst.last",  64'(mat_lsu_req_last),      64'd0);
        checkVal("rst.empty", 64'(mat_idu_ld_done_empty), 64'd0);
        cpurst_b = 1'b1;
        step();
        expectIdle("rst_rel");

        // 1: basic M operand, 3 rows; sizeM changes mid-flight must be ignored
        startOp(40'h1000, 40'h100, 1'b0, 8'd3, 8'd7, 16'd64, 7'd5);
        x_sizeM = 8'd9;
        expectReq("t1.r0", 40'h1000, 16'd64, 8'd0, 1'b0, 7'd5);
        step();
        expectReq("t1.r1", 40'h1100, 16'd64, 8'd1, 1'b0, 7'd5);
        step();
        expectReq("t1.r2", 40'h1200, 16'd64, 8'd2, 1'b1, 7'd5);
        step();
        expectDone("t1.done", 7'd5, 1'b0);
        step();
        expectIdle("t1.idle");

        // 2: backpressure on row 1 for two cycles
        startOp(40'h1000, 40'h100, 1'b0, 8'd3, 8'd0, 16'd64, 7'd6);
        expectReq("t2.r0", 40'h1000, 16'd64, 8'd0, 1'b0, 7'd6);
        step();
        lsu_mat_req_rdy = 1'b0;
        expectReq("t2.r1a", 40'h1100, 16'd64, 8'd1, 1'b0, 7'd6);
        step();
        expectReq("t2.r1b", 40'h1100, 16'd64, 8'd1, 1'b0, 7'd6);
        step();
        expectReq("t2.r1c", 40'h1100, 16'd64, 8'd1, 1'b0, 7'd6);
        lsu_mat_req_rdy = 1'b1;
        step();
        expectReq("t2.r2", 40'h1200, 16'd64, 8'd2, 1'b1, 7'd6);
        step();
        expectDone("t2.done", 7'd6, 1'b0);
        step();
        expectIdle("t2.idle");

        // 3: N operand selects sizeN
        startOp(40'h2000, 40'h40, 1'b1, 8'd5, 8'd2, 16'd16, 7'd9);
        expectReq("t3.r0", 40'h2000, 16'd16, 8'd0, 1'b0, 7'd9);
        step();
        expectReq("t3.r1", 40'h2040, 16'd16, 8'd1, 1'b1, 7'd9);
        step();
        expectDone("t3.done", 7'd9, 1'b0);
        step();
        expectIdle("t3.idle");

        // 4: zero sizeK, then zero row count
        startOp(40'h3000, 40'h10, 1'b0, 8'd4, 8'd0, 16'd0, 7'd11);
        expectDone("t4a.done", 7'd11, 1'b1);
        step();
        expectIdle("t4a.idle");
        startOp(40'h3000, 40'h10, 1'b0, 8'd0, 8'd3, 16'd8, 7'd12);
        expectDone("t4b.done", 7'd12, 1'b1);
        step();
        expectIdle("t4b.idle");

        // 5: flush during stalled row 1, then a clean op, then flush with sel
        startOp(40'h3000, 40'h100, 1'b0, 8'd3, 8'd0, 16'd32, 7'd20);
        expectReq("t5.r0", 40'h3000, 16'd32, 8'd0, 1'b0, 7'd20);
        step();
        lsu_mat_req_rdy = 1'b0;
        rtu_yy_xx_flush = 1'b1;
        expectReq("t5.r1", 40'h3100, 16'd32, 8'd1, 1'b0, 7'd20);
        step();
        rtu_yy_xx_flush = 1'b0;
        lsu_mat_req_rdy = 1'b1;
        expectIdle("t5.flush1");
        step();
        expectIdle("t5.flush2");
        startOp(40'h4000, 40'h20, 1'b0, 8'd2, 8'd0, 16'd8, 7'd21);
        expectReq("t5.n0", 40'h4000, 16'd8, 8'd0, 1'b0, 7'd21);
        step();
        expectReq("t5.n1", 40'h4020, 16'd8, 8'd1, 1'b1, 7'd21);
        step();
        expectDone("t5.ndone", 7'd21, 1'b0);
        step();
        expectIdle("t5.nidle");
        rtu_yy_xx_flush = 1'b1;
        startOp(40'h5000, 40'h20, 1'b0, 8'd2, 8'd0, 16'd8, 7'd22);
        rtu_yy_xx_flush = 1'b0;
        expectIdle("t5.selflush1");
        step();
        expectIdle("t5.selflush2");

        // 6: address wraps at 2^40
        startOp(40'hFF_FFFF_FF80, 40'h80, 1'b0, 8'd2, 8'd0, 16'd128, 7'd30);
        expectReq("t6.r0", 40'hFF_FFFF_FF80, 16'd128, 8'd0, 1'b0, 7'd30);
        step();
        expectReq("t6.r1", 40'h00_0000_0000, 16'd128, 8'd1, 1'b1, 7'd30);
        step();
        expectDone("t6.done", 7'd30, 1'b0);
        step();
        expectIdle("t6.idle");

        // Async reset mid-operation: outputs clear without a clock edge, no completion follows
        startOp(40'h6000, 40'h40, 1'b0, 8'd4, 8'd0, 16'd16, 7'd40);
        expectReq("rstmid.r0", 40'h6000, 16'd16, 8'd0, 1'b0, 7'd40);
        #2;
        cpurst_b = 1'b0;
        #1;
        expectIdle("rstmid.async");
        checkVal("rstmid.addr", 64'(mat_lsu_req_addr), 64'd0);
        step();
        cpurst_b = 1'b1;
        step();
        expectIdle("rstmid.after1");
        step();
        expectIdle("rstmid.after2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, missCnt);
        $finish;
    end

endmodule

// File: doc/ct_mat_lsu_ld_row_seq.md
# ct_mat_lsu_ld_row_seq

Matrix load row sequencer: the consumer of the configured tile sizes `x_sizeK`, `x_sizeM` and `x_sizeN`.
- On a matrix-load issue from the IDU rf stage, it snapshots the sizes, base address and row stride.
- It then issues one row request per matrix row to the LSU over a valid/ready handshake.
- When the last row is accepted, it reports completion back to the IDU.
- It sits between the config unit and LSU inside the matrix execution unit.

## Interface
Parameters:
- `ADDR_WIDTH`, 40, physical/virtual address width; address arithmetic wraps modulo 2^ADDR_WIDTH.
- `IID_WIDTH`, 7, instruction ID width.

Ports (reset `cpurst_b`, asynchronous, active-low; clock `forever_cpuclk`):
- `forever_cpuclk` in 1: clock.
- `cpurst_b` in 1: async active-low reset.
- `idu_mat_rf_ld_sel` in 1: start strobe, one cycle.
- `idu_mat_rf_ld_base` in ADDR_WIDTH: row-0 address.
- `idu_mat_rf_ld_stride` in ADDR_WIDTH: byte distance between consecutive rows.
- `idu_mat_rf_ld_use_n` in 1: 1 selects row count = sizeN (B operand); 0 selects row count = sizeM.
- `idu_mat_rf_ld_iid` in IID_WIDTH: instruction ID.
- `x_sizeK` in 16: bytes per row.
- `x_sizeM` in 8: row count when `use_n` = 0.
- `x_sizeN` in 8: row count when `use_n` = 1.
- `rtu_yy_xx_flush` in 1: pipeline flush.
- `lsu_mat_req_rdy` in 1: LSU accepts the request.
- `mat_lsu_req_vld` out 1: request valid.
- `mat_lsu_req_addr` out ADDR_WIDTH: row address.
- `mat_lsu_req_bytes` out 16: row length in bytes.
- `mat_lsu_req_row` out 8: row index.
- `mat_lsu_req_last` out 1: final row of the operation.
- `mat_lsu_req_iid` out IID_WIDTH: instruction ID.
- `mat_idu_ld_busy` out 1: sequencer occupied.
- `mat_idu_ld_done_vld` out 1: one-cycle completion pulse.
- `mat_idu_ld_done_iid` out IID_WIDTH: ID of the completed operation.
- `mat_idu_ld_done_empty` out 1: the operation issued zero rows.

## Operation
FSM states: IDLE, ISSUE, DONE.
- **IDLE → ISSUE:** on `sel` with no flush, when the snapshotted row count ≠ 0 and `sizeK` ≠ 0.
  - Snapshot base, stride, iid, `sizeK`, and row count (`sizeN` if `use_n`, else `sizeM`).
  - Set the row counter to 0 and the current address to base.
- **IDLE → DONE:** on `sel` when row count = 0 or `sizeK` = 0. `empty` is set to 1.
- **ISSUE:**
  - `req_vld` = 1; `addr`, `bytes`, `row` and `iid` come from the snapshot and counters.
  - `last` = (row == rowcnt − 1).
  - On `vld & rdy` with not last: row += 1, addr += stride (truncated to ADDR_WIDTH).
  - On `vld & rdy` with last: → DONE.
- **DONE:** `done_vld` = 1 for exactly one cycle, with `done_iid` and `done_empty`; then → IDLE.
- `busy` = (state ≠ IDLE).
- `sel` while `busy` = 1 is illegal: the IDU must not issue it. Bench assertion; RTL ignores it.
- Changes to `x_size*` after the start cycle do not affect an in-flight operation.
- **Flush:** in any state, the next state is IDLE. No `done_vld` is produced, and snapshot registers are don't-care. Flush has priority over `sel` and over handshake completion in the same cycle.
- **Reset values:** state IDLE; all outputs 0; counters, address and snapshot registers 0.

## Timing
- `sel` at cycle T: first `req_vld` at T+1, row 0.
- Request payload is held stable while `vld & !rdy`. `vld` never drops without a handshake, except on flush.
- With `rdy` held at 1, one row is issued per cycle. N rows: last handshake at T+N, `done_vld` at T+N+1, `busy` low at T+N+2. The earliest next `sel` is accepted at T+N+2.
- Zero-size case: `sel` at T, `done_vld` with `empty` = 1 at T+1, IDLE at T+2.
- Flush at cycle F: `req_vld`, `busy` and `done_vld` are all 0 at F+1.
- Reset asserted mid-operation: all outputs return to 0 asynchronously and state is IDLE. No completion is reported.

## Structure
- Shared package `ct_mat_pkg` holds:
  - the state enum (IDLE/ISSUE/DONE);
  - `SIZE_K_WIDTH` = 16, `SIZE_M_WIDTH` = 8, `SIZE_N_WIDTH` = 8;
  - default `MAT_ADDR_WIDTH` = 40.
- The config unit and this block share these constants.
- Single module: FSM, row counter, address accumulator and snapshot registers. No sub-module.

## Test plan
1. **Basic issue:** `sizeM`=3, `sizeK`=64, base `0x1000`, stride `0x100`, `rdy`=1, `use_n`=0. Expect requests `0x1000`/`0x1100`/`0x1200`, bytes 64, rows 0/1/2, `last` only on row 2, `done_vld` one cycle after, `empty`=0. Change `x_sizeM` to 9 at T+1; still exactly 3 rows.
2. **Backpressure:** as test 1 with `rdy` = 0 for 2 cycles while row 1 is presented. Row 1 payload is held (`0x1100`) for 3 cycles; total completion is delayed by 2 cycles.
3. **N operand:** `use_n`=1, `sizeN`=2, `sizeM`=5, `sizeK`=16. Expect exactly 2 requests; `last` on row 1.
4. **Zero size:** `sizeK`=0, `sizeM`=4. Expect no `req_vld`; `done_vld`=1 and `empty`=1 at T+1; `busy` low at T+2. Repeat with `sizeM`=0, `sizeK`=8: same result.
5. **Flush:** assert flush during row 1 with `rdy`=0. `req_vld` = 0 next cycle and no `done_vld`. A subsequent `sel` runs a clean 2-row operation from row 0. Also assert flush in the same cycle as `sel`: the operation never starts.
6. **Address wrap:** ADDR_WIDTH=40, base `0xFF_FFFF_FF80`, stride `0x80`, `sizeM`=2. Row 1 address is `0x00_0000_0000`.
